// File: rtl/mem_port_arbiter_if.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
//
// Bundles every signal between the memory port arbiter, its two requesters
// (CPU controller and DMA/program loader) and the single-port memory.
//
// Handshake (both requester ports): a requester raises req together with
// we/addr/wdata and holds all of them stable until it sees ack, which is a
// one-cycle pulse. req is only looked at while the arbiter is idle, so req
// still high in the cycle after ack is a new request. rdata is valid from the
// ack cycle onward and holds until the next read on the same port completes.
//
// Modports:
//   slave  - the arbiter side (drives acks, rdata, memory bus, status, debug)
//   master - the environment side (requesters and memory model)
//
// Signal summary:
//   cpu_req/cpu_we/cpu_addr/cpu_wdata  CPU request and command
//   cpu_ack/cpu_rdata                  CPU completion pulse and read data
//   dma_req/dma_we/dma_addr/dma_wdata  DMA request and command
//   dma_ack/dma_rdata                  DMA completion pulse and read data
//   mem_addr/mem_wdata/mem_we          memory command
//   mem_rdata                          memory read data
//   busy                               access in progress
//   grant_dma                          in-progress access belongs to DMA
//   dbg_state                          arbiter FSM state encoding
//   dbg_streak                         consecutive CPU grants while DMA waits
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if #(
    parameter int AW = 13,
    parameter int DW = 8
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rdata;

    logic          dma_req;
    logic          dma_we;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata;
    logic          dma_ack;
    logic [DW-1:0] dma_rdata;

    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;

    logic          busy;
    logic          grant_dma;

    logic [1:0]    dbg_state;
    logic [7:0]    dbg_streak;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_ack, dma_rdata,
        output mem_addr, mem_wdata, mem_we,
        input  mem_rdata,
        output busy, grant_dma,
        output dbg_state, dbg_streak
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_ack, dma_rdata,
        input  mem_addr, mem_wdata, mem_we,
        output mem_rdata,
        input  busy, grant_dma,
        input  dbg_state, dbg_streak
    );
endinterface

// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port data/instruction memory between the CPU controller
// and a DMA/program-loader requester. The CPU has fixed priority, but once it
// has been granted MAX_STREAK times in a row while DMA was waiting, the next
// grant goes to DMA. Each access runs through IDLE -> ACCESS -> DONE, with
// ACCESS lasting WAIT_STATES+1 cycles to cover the memory's read latency.
//
// Parameters:
//   AW          address width
//   DW          data width
//   WAIT_STATES extra memory cycles per access, 0..15 (4-bit counter)
//   MAX_STREAK  CPU grants allowed in a row while DMA waits, >= 1
//
// Ports:
//   clk   clock, rising edge
//   rst   asynchronous, active-high reset
//   bus   mem_port_arbiter_if.slave: both requester ports, memory bus,
//         busy/grant_dma status and FSM debug (dbg_state, dbg_streak)
//
// Timing: a request seen in IDLE in cycle N is acknowledged in cycle
// N+2+WAIT_STATES. The write strobe is asserted only in the first ACCESS
// cycle, so every write produces exactly one mem_we cycle. Reset while an
// access is in flight abandons it: no ack, and mem_we/busy/grant_dma fall
// immediately because they are decoded from the asynchronously reset state.
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int AW          = 13,
    parameter int DW          = 8,
    parameter int WAIT_STATES = 1,
    parameter int MAX_STREAK  = 4
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);

    localparam int            SW         = (MAX_STREAK < 1) ? 1 : $clog2(MAX_STREAK + 1);
    localparam logic [3:0]    WAIT_INIT  = 4'(WAIT_STATES);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t        state;
    state_t        state_n;

    // Command latched at grant time; the requester may drop req mid-access.
    logic          lat_we;
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_wdata;
    logic          owner_dma;

    logic [3:0]    wait_cnt;
    logic [SW-1:0] streak;
    logic          first_q;      // high only during the first ACCESS cycle

    logic [DW-1:0] cpu_rdata_q;
    logic [DW-1:0] dma_rdata_q;

    // Control strobes from the next-state logic.
    logic          load;         // grant made this cycle (IDLE -> ACCESS)
    logic          pick_dma;     // the grant goes to DMA
    logic          capture;      // last ACCESS cycle of a read
    logic          cpu_wins;

    // CPU priority unless DMA has already waited through MAX_STREAK CPU grants.
    assign cpu_wins = bus.cpu_req && !(bus.dma_req && (streak == STREAK_MAX));

    // -----------------------------------------------------------------------
    // FSM state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // -----------------------------------------------------------------------
    // FSM next state and outputs
    // -----------------------------------------------------------------------
    always_comb begin
        state_n       = state;
        load          = 1'b0;
        pick_dma      = 1'b0;
        capture       = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_we    = 1'b0;
        bus.cpu_ack   = 1'b0;
        bus.dma_ack   = 1'b0;
        bus.busy      = 1'b0;
        bus.grant_dma = 1'b0;

        case (state)
            ST_IDLE: begin
                if (bus.cpu_req || bus.dma_req) begin
                    load     = 1'b1;
                    pick_dma = !cpu_wins;
                    state_n  = ST_ACCESS;
                end
            end

            ST_ACCESS: begin
                bus.mem_addr  = lat_addr;
                bus.mem_wdata = lat_wdata;
                bus.mem_we    = lat_we && first_q;
                bus.busy      = 1'b1;
                bus.grant_dma = owner_dma;
                if (wait_cnt == 4'd0) begin
                    capture = !lat_we;
                    state_n = ST_DONE;
                end
            end

            ST_DONE: begin
                // Address and data stay on the bus; the strobe is already gone.
                bus.mem_addr  = lat_addr;
                bus.mem_wdata = lat_wdata;
                bus.busy      = 1'b1;
                bus.grant_dma = owner_dma;
                bus.cpu_ack   = !owner_dma;
                bus.dma_ack   = owner_dma;
                state_n       = ST_IDLE;
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Latched command, owner, wait counter and write-strobe qualifier
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            owner_dma <= 1'b0;
            wait_cnt  <= 4'd0;
            first_q   <= 1'b0;
        end else begin
            first_q <= load;
            if (load) begin
                owner_dma <= pick_dma;
                lat_we    <= pick_dma ? bus.dma_we    : bus.cpu_we;
                lat_addr  <= pick_dma ? bus.dma_addr  : bus.cpu_addr;
                lat_wdata <= pick_dma ? bus.dma_wdata : bus.cpu_wdata;
                wait_cnt  <= WAIT_INIT;
            end else if ((state == ST_ACCESS) && (wait_cnt != 4'd0)) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Anti-starvation streak. Only updated in IDLE, where arbitration happens:
    // DMA not waiting clears it, a DMA grant clears it, and each CPU grant
    // made over a waiting DMA counts up (saturating).
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            streak <= '0;
        end else if (state == ST_IDLE) begin
            if (!bus.dma_req) begin
                streak <= '0;
            end else if (load && pick_dma) begin
                streak <= '0;
            end else if (load && (streak != STREAK_MAX)) begin
                streak <= streak + SW'(1);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Per-port read data. Each register only changes when a read of its own
    // port completes; writes and the other port's reads leave it alone.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else if (capture) begin
            if (owner_dma) begin
                dma_rdata_q <= bus.mem_rdata;
            end else begin
                cpu_rdata_q <= bus.mem_rdata;
            end
        end
    end

    assign bus.cpu_rdata  = cpu_rdata_q;
    assign bus.dma_rdata  = dma_rdata_q;
    assign bus.dbg_state  = state;
    assign bus.dbg_streak = 8'(streak);

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Two arbiters: dut_a with WAIT_STATES=1 (registered memory model, one cycle
// read latency) and dut_b with WAIT_STATES=0 (combinational memory model).
// Directed stimulus pushes the hand-computed completion (port, cycle, rdata)
// and write strobes (cycle, addr, data) into expected queues; independent
// monitors pop and compare whenever an ack or mem_we appears.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;
    localparam int AW = 13;
    localparam int DW = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    logic mem_init;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus_a ();
    mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus_b ();

    mem_port_arbiter #(.AW(AW), .DW(DW), .WAIT_STATES(1), .MAX_STREAK(4)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a)
    );
    mem_port_arbiter #(.AW(AW), .DW(DW), .WAIT_STATES(0), .MAX_STREAK(4)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b)
    );

    // ---------------- memory models ----------------
    logic [7:0] mem_a [0:8191];
    logic [7:0] mem_b [0:8191];

    function automatic logic [7:0] init_val(input logic [12:0] a);
        case (a)
            13'h0010: init_val = 8'h5A;
            13'h0020: init_val = 8'h11;
            13'h0030: init_val = 8'h22;
            13'h0040: init_val = 8'h44;
            13'h0050: init_val = 8'h50;
            13'h0051: init_val = 8'h51;
            13'h0052: init_val = 8'h52;
            13'h0053: init_val = 8'h53;
            13'h0054: init_val = 8'h54;
            13'h0005: init_val = 8'h77;
            13'h1FFF: init_val = 8'hC3;
            default:  init_val = 8'h00;
        endcase
    endfunction

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 8192; i++) mem_a[i] <= init_val(13'(i));
        end else if (bus_a.mem_we) begin
            mem_a[bus_a.mem_addr] <= bus_a.mem_wdata;
        end
        bus_a.mem_rdata <= mem_a[bus_a.mem_addr];
    end

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 8192; i++) mem_b[i] <= init_val(13'(i));
        end else if (bus_b.mem_we) begin
            mem_b[bus_b.mem_addr] <= bus_b.mem_wdata;
        end
    end
    assign bus_b.mem_rdata = mem_b[bus_b.mem_addr];

    // ---------------- scoreboard ----------------
    // ack entry: [40:9] cycle, [8:1] rdata of the owning port, [0] is_dma
    logic [40:0] exp_a_q[$];
    logic [40:0] exp_b_q[$];
    // write entry: [52:21] cycle, [20:8] addr, [7:0] data
    logic [52:0] wr_a_q[$];
    logic [52:0] wr_b_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_ack(input bit on_b, input bit is_dma, input logic [7:0] rd, input int at);
        logic [40:0] e;
        e = {32'(at), rd, is_dma};
        if (on_b) exp_b_q.push_back(e);
        else      exp_a_q.push_back(e);
    endtask

    task automatic push_wr(input bit on_b, input logic [12:0] addr, input logic [7:0] data, input int at);
        logic [52:0] e;
        e = {32'(at), addr, data};
        if (on_b) wr_b_q.push_back(e);
        else      wr_a_q.push_back(e);
    endtask

    task automatic mon_ack(input bit on_b, input logic cack, input logic dack, input logic gd,
                           input logic [7:0] crd, input logic [7:0] drd);
        logic [40:0] e;
        string p;
        int n;
        p = on_b ? "b" : "a";
        n = on_b ? exp_b_q.size() : exp_a_q.size();
        if (n == 0) begin
            checks++;
            failures++;
            $display("FAIL ack_unexpected_%s actual cpu_ack=%0b dma_ack=%0b required=no ack (cycle %0d)",
                     p, cack, dack, cyc);
        end else begin
            if (on_b) e = exp_b_q.pop_front();
            else      e = exp_a_q.pop_front();
            check({"ack_port_", p}, {30'd0, cack, dack}, e[0] ? 32'd1 : 32'd2);
            check({"ack_cycle_", p}, 32'(cyc), e[40:9]);
            check({"ack_grant_dma_", p}, {31'd0, gd}, {31'd0, e[0]});
            check({"ack_rdata_", p}, {24'd0, (e[0] ? drd : crd)}, {24'd0, e[8:1]});
        end
    endtask

    task automatic mon_wr(input bit on_b, input logic [12:0] addr, input logic [7:0] data);
        logic [52:0] e;
        string p;
        int n;
        p = on_b ? "b" : "a";
        n = on_b ? wr_b_q.size() : wr_a_q.size();
        if (n == 0) begin
            checks++;
            failures++;
            $display("FAIL mem_we_unexpected_%s actual addr=0x%0h data=0x%0h required=no strobe (cycle %0d)",
                     p, addr, data, cyc);
        end else begin
            if (on_b) e = wr_b_q.pop_front();
            else      e = wr_a_q.pop_front();
            check({"wr_cycle_", p}, 32'(cyc), e[52:21]);
            check({"wr_addr_", p}, {19'd0, addr}, {19'd0, e[20:8]});
            check({"wr_data_", p}, {24'd0, data}, {24'd0, e[7:0]});
        end
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (bus_a.cpu_ack || bus_a.dma_ack)
            mon_ack(1'b0, bus_a.cpu_ack, bus_a.dma_ack, bus_a.grant_dma, bus_a.cpu_rdata, bus_a.dma_rdata);
        if (bus_a.mem_we) mon_wr(1'b0, bus_a.mem_addr, bus_a.mem_wdata);
    end

    always @(negedge clk) begin
        if (bus_b.cpu_ack || bus_b.dma_ack)
            mon_ack(1'b1, bus_b.cpu_ack, bus_b.dma_ack, bus_b.grant_dma, bus_b.cpu_rdata, bus_b.dma_rdata);
        if (bus_b.mem_we) mon_wr(1'b1, bus_b.mem_addr, bus_b.mem_wdata);
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input bit on_b, input bit is_dma, input logic req, input logic we,
                         input logic [12:0] addr, input logic [7:0] wd);
        if (!on_b && !is_dma) begin
            bus_a.cpu_req = req; bus_a.cpu_we = we; bus_a.cpu_addr = addr; bus_a.cpu_wdata = wd;
        end else if (!on_b && is_dma) begin
            bus_a.dma_req = req; bus_a.dma_we = we; bus_a.dma_addr = addr; bus_a.dma_wdata = wd;
        end else if (on_b && !is_dma) begin
            bus_b.cpu_req = req; bus_b.cpu_we = we; bus_b.cpu_addr = addr; bus_b.cpu_wdata = wd;
        end else begin
            bus_b.dma_req = req; bus_b.dma_we = we; bus_b.dma_addr = addr; bus_b.dma_wdata = wd;
        end
    endtask

    task automatic drop(input bit on_b, input bit is_dma);
        drive(on_b, is_dma, 1'b0, 1'b0, 13'h0, 8'h00);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        rst      = 1'b1;
        mem_init = 1'b1;
        drop(0, 0); drop(0, 1); drop(1, 0); drop(1, 1);
        step(2);
        mem_init = 1'b0;
        rst      = 1'b0;

        // Reset state
        check("rst_busy_a",      {31'd0, bus_a.busy},      32'd0);
        check("rst_grant_dma_a", {31'd0, bus_a.grant_dma}, 32'd0);
        check("rst_mem_we_a",    {31'd0, bus_a.mem_we},    32'd0);
        check("rst_mem_addr_a",  {19'd0, bus_a.mem_addr},  32'd0);
        check("rst_mem_wdata_a", {24'd0, bus_a.mem_wdata}, 32'd0);
        check("rst_acks_a",      {30'd0, bus_a.cpu_ack, bus_a.dma_ack}, 32'd0);
        check("rst_cpu_rdata_a", {24'd0, bus_a.cpu_rdata}, 32'd0);
        check("rst_dma_rdata_a", {24'd0, bus_a.dma_rdata}, 32'd0);
        check("rst_state_a",     {30'd0, bus_a.dbg_state}, 32'd0);
        check("rst_streak_a",    {24'd0, bus_a.dbg_streak}, 32'd0);
        check("rst_busy_b",      {31'd0, bus_b.busy},      32'd0);
        check("rst_rdata_b",     {16'd0, bus_b.cpu_rdata, bus_b.dma_rdata}, 32'd0);
        step(1);

        // 1: CPU read 0x010 -> 0x5A, no write strobe, ack at N+3
        n = cyc;
        push_ack(0, 0, 8'h5A, n + 3);
        drive(0, 0, 1'b1, 1'b0, 13'h010, 8'h00);
        step(3); drop(0, 0); step(1);

        // 2: CPU write 0x0A3 <- 0x3C, single strobe at N+1, cpu_rdata untouched
        n = cyc;
        push_wr(0, 13'h0A3, 8'h3C, n + 1);
        push_ack(0, 0, 8'h5A, n + 3);
        drive(0, 0, 1'b1, 1'b1, 13'h0A3, 8'h3C);
        step(3); drop(0, 0); step(1);

        // 2b: read back the written location
        n = cyc;
        push_ack(0, 0, 8'h3C, n + 3);
        drive(0, 0, 1'b1, 1'b0, 13'h0A3, 8'h00);
        step(3); drop(0, 0); step(1);

        // 3: simultaneous requests, streak 0: CPU first, DMA one access later
        n = cyc;
        push_ack(0, 0, 8'h11, n + 3);
        push_ack(0, 1, 8'h22, n + 7);
        drive(0, 0, 1'b1, 1'b0, 13'h020, 8'h00);
        drive(0, 1, 1'b1, 1'b0, 13'h030, 8'h00);
        step(3); drop(0, 0);
        step(4); drop(0, 1); step(1);

        // 4: CPU back-to-back with DMA waiting: four CPU acks, then DMA
        n = cyc;
        push_ack(0, 0, 8'h50, n + 3);
        push_ack(0, 0, 8'h51, n + 7);
        push_ack(0, 0, 8'h52, n + 11);
        push_ack(0, 0, 8'h53, n + 15);
        push_ack(0, 1, 8'h44, n + 19);
        push_ack(0, 0, 8'h54, n + 23);
        drive(0, 0, 1'b1, 1'b0, 13'h050, 8'h00);
        drive(0, 1, 1'b1, 1'b0, 13'h040, 8'h00);
        step(3);  drive(0, 0, 1'b1, 1'b0, 13'h051, 8'h00);
        step(4);  drive(0, 0, 1'b1, 1'b0, 13'h052, 8'h00);
        step(4);  drive(0, 0, 1'b1, 1'b0, 13'h053, 8'h00);
        step(2);
        check("streak_sat_a", {24'd0, bus_a.dbg_streak}, 32'd4);
        step(2);  drive(0, 0, 1'b1, 1'b0, 13'h054, 8'h00);
        step(2);
        check("dma_grant_a", {31'd0, bus_a.grant_dma}, 32'd1);
        check("streak_clr_on_dma_a", {24'd0, bus_a.dbg_streak}, 32'd0);
        step(2);  drop(0, 1);
        step(4);  drop(0, 0);
        step(1);
        check("streak_after_a", {24'd0, bus_a.dbg_streak}, 32'd0);

        // 5: zero wait states: ack at N+2, DMA read of 0x1FFF leaves cpu_rdata alone
        n = cyc;
        push_ack(1, 0, 8'h77, n + 2);
        drive(1, 0, 1'b1, 1'b0, 13'h005, 8'h00);
        step(2); drop(1, 0); step(1);
        n = cyc;
        push_ack(1, 1, 8'hC3, n + 2);
        drive(1, 1, 1'b1, 1'b0, 13'h1FFF, 8'h00);
        step(2); drop(1, 1); step(1);
        check("cpu_rdata_kept_b", {24'd0, bus_b.cpu_rdata}, 32'h77);
        n = cyc;
        push_wr(1, 13'h200, 8'h99, n + 1);
        push_ack(1, 1, 8'hC3, n + 2);
        drive(1, 1, 1'b1, 1'b1, 13'h200, 8'h99);
        step(2); drop(1, 1); step(1);

        // 6: reset in the middle of a DMA write: outputs drop at once, no ack
        n = cyc;
        push_wr(0, 13'h100, 8'hEE, n + 1);
        drive(0, 1, 1'b1, 1'b1, 13'h100, 8'hEE);
        step(1);
        #2 rst = 1'b1;
        #1;
        check("rst_async_mem_we_a",    {31'd0, bus_a.mem_we},    32'd0);
        check("rst_async_busy_a",      {31'd0, bus_a.busy},      32'd0);
        check("rst_async_grant_dma_a", {31'd0, bus_a.grant_dma}, 32'd0);
        drop(0, 1);
        step(1);
        rst = 1'b0;
        check("rst_cpu_rdata_clr_a", {24'd0, bus_a.cpu_rdata}, 32'd0);
        step(1);
        n = cyc;
        push_ack(0, 0, 8'h5A, n + 3);
        drive(0, 0, 1'b1, 1'b0, 13'h010, 8'h00);
        step(3); drop(0, 0);

        step(5);
        check("pending_acks_a",   32'(exp_a_q.size()), 32'd0);
        check("pending_acks_b",   32'(exp_b_q.size()), 32'd0);
        check("pending_writes_a", 32'(wr_a_q.size()),  32'd0);
        check("pending_writes_b", 32'(wr_b_q.size()),  32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        failures++;
        $display("FAIL watchdog actual=time limit reached required=stimulus complete");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
